seg_decode_mux: RTL

//  Inverse of the hex-to-7-segment encoder. Snoops a 2-digit time-multiplexed

---
 rtl/seg_decode_mux.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_decode_mux.sv
// seg_decode_mux
//   Snoops a 2-digit time-multiplexed common-anode 7-segment bus and recovers
//   the hex value shown on each digit. A digit's value is committed only after
//   STABLE consecutive identical decodes. Illegal segment patterns, and both
//   digit enables active at once, raise a sticky error.
//
// Parameters
//   SETTLE  cycles an must stay unchanged before seg is sampled in a window (>=1)
//   STABLE  consecutive identical decodes needed to commit a digit (>=1)
//
// Ports
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   seg      snooped segments {g,f,e,d,c,b,a}, active-low
//   an       snooped digit enables, active-low; an[0] right, an[1] left
//   err_clr  synchronous clear of err (a same-cycle error set wins)
//   hexL     committed left-digit value
//   hexR     committed right-digit value
//   valid    sticky: both digits have committed since reset
//   update   one-cycle pulse when hexL or hexR first commits or changes
//   err      sticky error flag
module seg_decode_mux #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  input  logic       err_clr,
  output logic [3:0] hexL,
  output logic [3:0] hexR,
  output logic       valid,
  output logic       update,
  output logic       err
);

  localparam int unsigned SW  = $clog2(SETTLE + 1);
  localparam int unsigned STW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {
    StWait,
    StSettle,
    StHold
  } state_e;

  // Digit index 1 = left, 0 = right, matching the an[] bit positions.
  state_e               state_q, state_d;
  logic [1:0]           an_q;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic                 dig_q, dig_d;
  logic [1:0][3:0]      cand_q, cand_d;
  logic [1:0][STW-1:0]  cnt_q, cnt_d;
  logic [1:0][3:0]      hex_q, hex_d;
  logic [1:0]           com_q, com_d;
  logic                 valid_q, valid_d;
  logic                 upd_q, upd_d;
  logic                 err_q, err_d;

  logic                 an_chg;
  logic                 enter;
  logic                 sample;
  logic                 sdig;
  logic                 err_an;
  logic                 err_ill;
  logic                 dec_legal;
  logic                 dec_blank;
  logic [3:0]           dec_hex;

  assign an_chg = (an != an_q);

  // ---------------------------------------------------------------------------
  // Window FSM: decides on which edge seg is sampled and for which digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    dig_d   = dig_q;
    sample  = 1'b0;
    err_an  = 1'b0;
    enter   = 1'b0;

    unique case (state_q)
      StWait: enter = 1'b1;
      StSettle: begin
        if (an_chg) begin
          enter = 1'b1;
        end else begin
          if (scnt_q != SW'(SETTLE)) begin
            scnt_d = scnt_q + SW'(1);
          end
          // This edge is the SETTLE-th of the window.
          if (scnt_q == SW'(SETTLE - 1)) begin
            sample  = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (an_chg) begin
          enter = 1'b1;
        end
      end
      default: state_d = StWait;
    endcase

    // Evaluate the current enables as if idle: start a window, stay idle or flag a clash.
    if (enter) begin
      unique case (an)
        2'b11: state_d = StWait;
        2'b00: begin
          err_an  = 1'b1;
          state_d = StWait;
        end
        default: begin
          dig_d  = ~an[1];
          scnt_d = SW'(1);
          if (SETTLE == 1) begin
            sample  = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StSettle;
          end
        end
      endcase
    end
  end

  // dig_d equals dig_q unless the window starts (and samples) on this edge.
  assign sdig = dig_d;

  // ---------------------------------------------------------------------------
  // Segment decode (active-low segments).
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_hex   = 4'h0;
    unique case (seg)
      7'h40: dec_hex = 4'h0;
      7'h79: dec_hex = 4'h1;
      7'h24: dec_hex = 4'h2;
      7'h30: dec_hex = 4'h3;
      7'h19: dec_hex = 4'h4;
      7'h12: dec_hex = 4'h5;
      7'h02: dec_hex = 4'h6;
      7'h78: dec_hex = 4'h7;
      7'h00: dec_hex = 4'h8;
      7'h18: dec_hex = 4'h9;
      7'h08: dec_hex = 4'hA;
      7'h03: dec_hex = 4'hB;
      7'h46: dec_hex = 4'hC;
      7'h21: dec_hex = 4'hD;
      7'h06: dec_hex = 4'hE;
      7'h0E: dec_hex = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-digit candidate tracking and commit.
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    com_d   = com_q;
    upd_d   = 1'b0;
    err_ill = 1'b0;

    if (sample) begin
      if (dec_legal) begin
        if (dec_hex == cand_q[sdig]) begin
          if (cnt_q[sdig] != STW'(STABLE)) begin
            cnt_d[sdig] = cnt_q[sdig] + STW'(1);
          end
        end else begin
          cand_d[sdig] = dec_hex;
          cnt_d[sdig]  = STW'(1);
        end
        // Commit on reaching STABLE only if it is new information; saturated
        // repeats of the committed value stay silent.
        if (cnt_d[sdig] == STW'(STABLE) &&
            (!com_q[sdig] || dec_hex != hex_q[sdig])) begin
          hex_d[sdig] = dec_hex;
          com_d[sdig] = 1'b1;
          upd_d       = 1'b1;
        end
      end else if (dec_blank) begin
        cnt_d[sdig] = '0;
      end else begin
        err_ill     = 1'b1;
        cnt_d[sdig] = '0;
      end
    end

    valid_d = valid_q | (&com_d);

    // Set takes priority over clear.
    if (err_an || err_ill) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StWait;
      an_q    <= 2'b11;
      scnt_q  <= '0;
      dig_q   <= 1'b0;
      cand_q  <= '0;
      cnt_q   <= '0;
      hex_q   <= '0;
      com_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      an_q    <= an;
      scnt_q  <= scnt_d;
      dig_q   <= dig_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      com_q   <= com_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign hexL   = hex_q[1];
  assign hexR   = hex_q[0];
  assign valid  = valid_q;
  assign update = upd_q;
  assign err    = err_q;

endmodule
